hazard_unit: RTL and testbench

Pipeline control block that sits upstream of the forwarding unit and decides, each cycle, whether the FD and DX pipeline registers advance, hold or take a bubble. It covers four cases:
- Load-use stalls that forwarding cannot cover.
- Taken-branch flushes.
- Global freezes on data-memory wait.
- The HLT drain sequence.

It guarantees that every RAW case reaching DX is one that XX, MX or MM forwarding resolves.

---
 rtl/hazard_unit.sv | 171 +++++++++++++++++
 tb/tb_hazard_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the FD/DX stages.
// Decides each cycle whether PC/FD advance, hold or take a bubble.
// It covers load-use stalls, taken-branch flushes, data-memory freezes
// and the HLT drain sequence.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush counters.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal issue; branch flush, load-use stall or HLT entry decided
// DRAIN   | HLT held in FD, bubbles fed into DX while DX/XM/MW empty out
// HALTED  | processor stopped, only rst leaves this state
module hazard_unit #(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  fd_rs,
   input  logic [3:0]  fd_rt,
   input  logic        fd_uses_rs,
   input  logic        fd_uses_rt,
   input  logic        fd_is_store,
   input  logic        fd_halt,
   input  logic        dx_memread,
   input  logic [3:0]  dx_rd,
   input  logic        br_taken,
   input  logic        mem_stall,
   output logic        pc_write,
   output logic        fd_write,
   output logic        fd_flush,
   output logic        dx_flush,
   output logic        pipe_write,
   output logic        halted
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [1:0] CNT_LAST = 2'(DRAIN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       halted_q, halted_d;
   logic       load_use;

   // A store's Rt is store data, which MM forwarding delivers, so it never stalls.
   always_comb begin
      load_use = dx_memread && (dx_rd != 4'd0) &&
                 ((fd_uses_rs && (dx_rd == fd_rs)) ||
                  (fd_uses_rt && !fd_is_store && (dx_rd == fd_rt)));
   end

   // Next-state and Mealy enable/flush decode, highest priority first.
   always_comb begin
      pc_write   = 1'b1;
      fd_write   = 1'b1;
      fd_flush   = 1'b0;
      dx_flush   = 1'b0;
      pipe_write = 1'b1;
      state_d    = state_q;
      cnt_d      = cnt_q;
      halted_d   = (state_q == ST_HALTED);

      if (rst) begin
         pc_write   = 1'b0;
         fd_write   = 1'b0;
         fd_flush   = 1'b1;
         dx_flush   = 1'b1;
         pipe_write = 1'b0;
         state_d    = ST_RUN;
         cnt_d      = 2'd0;
         halted_d   = 1'b0;
      end else if (mem_stall) begin
         pc_write   = 1'b0;
         fd_write   = 1'b0;
         pipe_write = 1'b0;
         halted_d   = halted_q;
      end else begin
         unique case (state_q)
            ST_HALTED: begin
               pc_write   = 1'b0;
               fd_write   = 1'b0;
               pipe_write = 1'b0;
            end
            ST_DRAIN: begin
               pc_write = 1'b0;
               fd_write = 1'b0;
               dx_flush = 1'b1;
               cnt_d    = 2'(cnt_q + 2'd1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_HALTED;
               end
            end
            ST_RUN: begin
               // A taken branch squashes the FD instruction, so it overrides
               // both a load-use hazard and HLT sitting in FD.
               if (br_taken) begin
                  fd_flush = 1'b1;
                  dx_flush = 1'b1;
               end else if (load_use) begin
                  pc_write = 1'b0;
                  fd_write = 1'b0;
                  dx_flush = 1'b1;
               end else if (fd_halt) begin
                  pc_write = 1'b0;
                  fd_write = 1'b0;
                  dx_flush = 1'b1;
                  state_d  = ST_DRAIN;
                  cnt_d    = 2'd0;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   // State, drain counter and halted flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         cnt_q    <= 2'd0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

`ifdef HAZARD_PERF_EN
   logic        stall_ev, flush_ev;
   logic [15:0] stall_q, flush_q;

   // Events only count when the corresponding RUN case actually wins priority.
   always_comb begin
      flush_ev = !mem_stall && (state_q == ST_RUN) && br_taken;
      stall_ev = !mem_stall && (state_q == ST_RUN) && !br_taken && load_use;
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         if (stall_ev && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (flush_ev && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table plus drain/reset sequences for hazard_unit.
module tb_hazard_unit;

   logic       clk;
   logic       rst;
   logic [3:0] fd_rs, fd_rt, dx_rd;
   logic       fd_uses_rs, fd_uses_rt, fd_is_store, fd_halt;
   logic       dx_memread, br_taken, mem_stall;
   logic       pc_write, fd_write, fd_flush, dx_flush, pipe_write, halted;
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_count, flush_count;
`endif

   int checks   = 0;
   int failures = 0;

   hazard_unit #(.DRAIN_CYCLES(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .fd_rs       (fd_rs),
      .fd_rt       (fd_rt),
      .fd_uses_rs  (fd_uses_rs),
      .fd_uses_rt  (fd_uses_rt),
      .fd_is_store (fd_is_store),
      .fd_halt     (fd_halt),
      .dx_memread  (dx_memread),
      .dx_rd       (dx_rd),
      .br_taken    (br_taken),
      .mem_stall   (mem_stall),
      .pc_write    (pc_write),
      .fd_write    (fd_write),
      .fd_flush    (fd_flush),
      .dx_flush    (dx_flush),
      .pipe_write  (pipe_write),
      .halted      (halted)
`ifdef HAZARD_PERF_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_write, fd_write, fd_flush, dx_flush, pipe_write}
   localparam logic [4:0] O_DEF   = 5'b11001;
   localparam logic [4:0] O_STALL = 5'b00011;
   localparam logic [4:0] O_BR    = 5'b11111;
   localparam logic [4:0] O_FRZ   = 5'b00000;
   localparam logic [4:0] O_RST   = 5'b00110;

   logic [4:0] outs;
   assign outs = {pc_write, fd_write, fd_flush, dx_flush, pipe_write};

   typedef struct {
      string      name;
      logic [3:0] rs, rt, rd;
      logic       uses_rs, uses_rt, is_store, memread, br, ms;
      logic [4:0] exp;
      int         stall_inc, flush_inc;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input string name, input logic [3:0] rs, rt, rd,
                               input logic uses_rs, uses_rt, is_store, memread, br, ms,
                               input logic [4:0] exp, input int si, fi);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.rd = rd;
      v.uses_rs = uses_rs; v.uses_rt = uses_rt; v.is_store = is_store;
      v.memread = memread; v.br = br; v.ms = ms;
      v.exp = exp; v.stall_inc = si; v.flush_inc = fi;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      fd_rs = 4'd0; fd_rt = 4'd0; dx_rd = 4'd0;
      fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; fd_is_store = 1'b0; fd_halt = 1'b0;
      dx_memread = 1'b0; br_taken = 1'b0; mem_stall = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1 chk("rst_outputs", 16'(outs), 16'(O_RST));
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rst_halted", 16'(halted), 16'd0);
      chk("rst_run_outputs", 16'(outs), 16'(O_DEF));
`ifdef HAZARD_PERF_EN
      chk("rst_stall_count", stall_count, 16'd0);
      chk("rst_flush_count", flush_count, 16'd0);
`endif
   endtask

   // HLT entry then drain; optional 2-cycle mem_stall starting at drain edge index stall_start.
   task automatic run_drain(input int stall_start, input int exp_edges, input string tag);
      int  n;
      bit  got;
      @(negedge clk);
      idle_inputs();
      fd_halt = 1'b1;
      #1 chk({tag, "_hlt_entry"}, 16'(outs), 16'(O_STALL));
      @(posedge clk);
      n = 0;
      got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         mem_stall = (stall_start >= 0) && (n >= stall_start) && (n < stall_start + 2);
         #1;
         if (n == 0) chk({tag, "_drain_outputs"}, 16'(outs), 16'(O_STALL));
         if (mem_stall) chk({tag, "_drain_freeze"}, 16'(outs), 16'(O_FRZ));
         @(posedge clk);
         n++;
         #1 if (halted) got = 1;
      end
      chk({tag, "_halted_seen"}, 16'(got), 16'd1);
      chk({tag, "_halt_edges"}, 16'(n), 16'(exp_edges));
      @(negedge clk);
      mem_stall = 1'b0;
      #1 chk({tag, "_halted_outputs"}, 16'(outs), 16'(O_FRZ));
      @(posedge clk);
      #1 chk({tag, "_halted_stays"}, 16'(halted), 16'd1);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      vecs[0]  = mk("idle",          4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, O_DEF,   0, 0);
      vecs[1]  = mk("lu_rs",         4'd5, 4'd0, 4'd5, 1, 0, 0, 1, 0, 0, O_STALL, 1, 0);
      vecs[2]  = mk("lu_rs_cleared", 4'd5, 4'd0, 4'd5, 1, 0, 0, 0, 0, 0, O_DEF,   0, 0);
      vecs[3]  = mk("lu_rt",         4'd0, 4'd7, 4'd7, 0, 1, 0, 1, 0, 0, O_STALL, 1, 0);
      vecs[4]  = mk("store_data",    4'd0, 4'd3, 4'd3, 0, 1, 1, 1, 0, 0, O_DEF,   0, 0);
      vecs[5]  = mk("store_rs",      4'd3, 4'd3, 4'd3, 1, 1, 1, 1, 0, 0, O_STALL, 1, 0);
      vecs[6]  = mk("reg_zero",      4'd0, 4'd0, 4'd0, 1, 1, 0, 1, 0, 0, O_DEF,   0, 0);
      vecs[7]  = mk("rs_unused",     4'd5, 4'd0, 4'd5, 0, 0, 0, 1, 0, 0, O_DEF,   0, 0);
      vecs[8]  = mk("no_load",       4'd5, 4'd0, 4'd5, 1, 0, 0, 0, 0, 0, O_DEF,   0, 0);
      vecs[9]  = mk("branch",        4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, O_BR,    0, 1);
      vecs[10] = mk("branch_lu",     4'd5, 4'd0, 4'd5, 1, 0, 0, 1, 1, 0, O_BR,    0, 1);
      vecs[11] = mk("memstall_lu",   4'd5, 4'd0, 4'd5, 1, 0, 0, 1, 0, 1, O_FRZ,   0, 0);
      vecs[12] = mk("memstall_br",   4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, O_FRZ,   0, 0);
      vecs[13] = mk("rd_mismatch",   4'd5, 4'd5, 4'd6, 1, 1, 0, 1, 0, 0, O_DEF,   0, 0);

      do_reset();

      for (int i = 0; i < 14; i++) begin
`ifdef HAZARD_PERF_EN
         logic [15:0] s0, f0;
`endif
         @(negedge clk);
         fd_rs = vecs[i].rs; fd_rt = vecs[i].rt; dx_rd = vecs[i].rd;
         fd_uses_rs = vecs[i].uses_rs; fd_uses_rt = vecs[i].uses_rt;
         fd_is_store = vecs[i].is_store; dx_memread = vecs[i].memread;
         br_taken = vecs[i].br; mem_stall = vecs[i].ms; fd_halt = 1'b0;
         #1 chk(vecs[i].name, 16'(outs), 16'(vecs[i].exp));
`ifdef HAZARD_PERF_EN
         s0 = stall_count;
         f0 = flush_count;
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_stall_cnt"}, stall_count, s0 + 16'(vecs[i].stall_inc));
         chk({vecs[i].name, "_flush_cnt"}, flush_count, f0 + 16'(vecs[i].flush_inc));
`endif
      end

      // Branch overrides HLT in FD: stays RUN, later idle cycle gives defaults.
      @(negedge clk);
      idle_inputs();
      fd_halt = 1'b1;
      br_taken = 1'b1;
      #1 chk("branch_over_hlt", 16'(outs), 16'(O_BR));
      @(negedge clk);
      idle_inputs();
      #1 chk("after_branch_hlt", 16'(outs), 16'(O_DEF));

      // Plain drain: halted on the 4th edge after the edge that latched DRAIN.
      do_reset();
      run_drain(-1, 4, "drain");

      // Reset while halted returns to RUN on the next edge.
      do_reset();
      chk("rst_from_halted", 16'(halted), 16'd0);

      // Two mem_stall cycles inside DRAIN delay halted by exactly two edges.
      run_drain(1, 6, "drain_ms");

      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
